// File: rtl/r22sdf_pkg.sv
// ---------------------------------------------------------------------------
// r22sdf_pkg
// Shared types and helpers for the R2^2SDF pipeline stages.
//   seq_state_t : frame sequencer state (IDLE / RUN)
//   tw_mult_k   : twiddle multiplier K for quarter index Q (0/2/1/3)
//   tw_lat      : total ROM + converter latency in clock cycles
// ---------------------------------------------------------------------------
package r22sdf_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

   // Quarter 0 has no rotation; quarters 1/2/3 use twiddle multipliers 2/1/3.
   function automatic logic [1:0] tw_mult_k(input logic [1:0] q);
      case (q)
         2'd0:    tw_mult_k = 2'd0;
         2'd1:    tw_mult_k = 2'd2;
         2'd2:    tw_mult_k = 2'd1;
         default: tw_mult_k = 2'd3;
      endcase
   endfunction

   function automatic int tw_lat(input int rom_ff, input int tw_ff, input int tc_ff);
      return rom_ff + tw_ff + tc_ff;
   endfunction

endpackage

// File: rtl/twiddle_delay_line.sv
// ---------------------------------------------------------------------------
// twiddle_delay_line
// Fixed-depth shift register used to keep side-band bits aligned with a
// pipelined datapath. DEPTH=0 is a pure wire.
//   clock     : clock
//   reset     : synchronous active-high reset, clears every stage
//   din       : WIDTH-bit input word, shifted in every cycle
//   dout      : din delayed by DEPTH cycles
//   lane0_any : OR of bit 0 of every stage (bit 0 is the valid lane), so the
//               owner can tell whether anything is still in flight
// ---------------------------------------------------------------------------
module twiddle_delay_line #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             lane0_any
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign dout      = din;
         assign lane0_any = 1'b0;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_reg [DEPTH];
         logic [DEPTH-1:0] lane0_bits;

         always_ff @(posedge clock) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_reg[i] <= '0;
               end
            end else begin
               stage_reg[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_reg[i] <= stage_reg[i-1];
               end
            end
         end

         for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            assign lane0_bits[gi] = stage_reg[gi][0];
         end

         assign dout      = stage_reg[DEPTH-1];
         assign lane0_any = |lane0_bits;
      end
   endgenerate

endmodule

// File: rtl/twiddle_sequencer.sv
// ---------------------------------------------------------------------------
// twiddle_sequencer
// Twiddle-address generator for one R2^2SDF multiplier stage. Counts accepted
// samples within an N = 2**LOG_N point frame, issues the twiddle number and
// delays valid/first/last markers by the ROM + converter latency.
// LOG_N must be at least 3.
//   clock    : clock
//   reset    : synchronous active-high reset
//   di_en    : sample accepted this cycle
//   frm_clr  : frame realign; the current sample (if any) becomes index 0
//   tw_addr  : twiddle number P*K for the current sample (combinational)
//   tw_en    : tw_addr valid (= di_en)
//   tc_en    : tw_en delayed by ROM_FF+TW_FF+TC_FF cycles
//   tc_first : tc_en-aligned marker of index 0
//   tc_last  : tc_en-aligned marker of index N-1
//   busy     : frame partially received or markers still in flight
//   frm_cnt  : (only with TWSEQ_FRAME_CNT_EN) wrapping count of tc_last pulses
// Build option: define TWSEQ_FRAME_CNT_EN to add the frm_cnt output.
// ---------------------------------------------------------------------------
module twiddle_sequencer
   import r22sdf_pkg::*;
#(
   parameter int LOG_N  = 6,
   parameter int ROM_FF = 1,
   parameter int TW_FF  = 1,
   parameter int TC_FF  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             di_en,
   input  logic             frm_clr,
   output logic [LOG_N-1:0] tw_addr,
   output logic             tw_en,
   output logic             tc_en,
   output logic             tc_first,
   output logic             tc_last,
   output logic             busy
`ifdef TWSEQ_FRAME_CNT_EN
   ,
   output logic [15:0]      frm_cnt
`endif
);

   localparam int LAT = tw_lat(ROM_FF, TW_FF, TC_FF);

   seq_state_t       state_reg;
   logic [LOG_N-1:0] cnt_reg;
   logic [LOG_N-1:0] idx;
   logic [1:0]       quad;
   logic [1:0]       k;
   logic [LOG_N-1:0] p_ext;
   logic             is_first;
   logic             is_last;
   logic             inflight;

   // A realign on the same cycle as a sample makes that sample index 0.
   assign idx      = frm_clr ? '0 : cnt_reg;
   assign quad     = idx[LOG_N-1:LOG_N-2];
   assign p_ext    = {2'b00, idx[LOG_N-3:0]};
   assign k        = tw_mult_k(quad);

   // P*K with K in 0..3 as shift/add; 3*(N/4-1) fits in LOG_N bits.
   assign tw_addr  = (k[1] ? (p_ext << 1) : '0) + (k[0] ? p_ext : '0);
   assign tw_en    = di_en;
   assign is_first = di_en && (idx == '0);
   assign is_last  = di_en && (idx == '1);

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_reg   <= '0;
         state_reg <= IDLE;
      end else if (frm_clr) begin
         cnt_reg   <= {{(LOG_N-1){1'b0}}, di_en};
         state_reg <= di_en ? RUN : IDLE;
      end else if (di_en) begin
         cnt_reg   <= cnt_reg + 1'b1;
         state_reg <= (cnt_reg == '1) ? IDLE : RUN;
      end
   end

   twiddle_delay_line #(
      .DEPTH (LAT),
      .WIDTH (3)
   ) u_delay (
      .clock     (clock),
      .reset     (reset),
      .din       ({is_last, is_first, di_en}),
      .dout      ({tc_last, tc_first, tc_en}),
      .lane0_any (inflight)
   );

   assign busy = (state_reg == RUN) || inflight;

`ifdef TWSEQ_FRAME_CNT_EN
   logic [15:0] frm_cnt_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         frm_cnt_reg <= '0;
      end else if (tc_last) begin
         frm_cnt_reg <= frm_cnt_reg + 16'd1;
      end
   end

   assign frm_cnt = frm_cnt_reg;
`endif

endmodule

// File: tb/tb_twiddle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_twiddle_sequencer
// Drives a LOG_N=6 sequencer with the default 3-cycle latency and a
// zero-latency copy from the same stimulus. A reference model predicts the
// twiddle number per sample and queues the expected tc markers with their
// due cycle; the queue is popped when the delayed outputs appear.
// ---------------------------------------------------------------------------
module tb_twiddle_sequencer;

   localparam int LOG_N = 6;
   localparam int N     = 64;
   localparam int LAT   = 3;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             di_en = 1'b0;
   logic             frm_clr = 1'b0;

   logic [LOG_N-1:0] tw_addr,  tw_addr0;
   logic             tw_en,    tw_en0;
   logic             tc_en,    tc_en0;
   logic             tc_first, tc_first0;
   logic             tc_last,  tc_last0;
   logic             busy,     busy0;
`ifdef TWSEQ_FRAME_CNT_EN
   logic [15:0]      frm_cnt,  frm_cnt0;
`endif

   always #5 clock = ~clock;

   twiddle_sequencer #(.LOG_N(LOG_N), .ROM_FF(1), .TW_FF(1), .TC_FF(1)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .di_en    (di_en),
      .frm_clr  (frm_clr),
      .tw_addr  (tw_addr),
      .tw_en    (tw_en),
      .tc_en    (tc_en),
      .tc_first (tc_first),
      .tc_last  (tc_last),
      .busy     (busy)
`ifdef TWSEQ_FRAME_CNT_EN
      ,
      .frm_cnt  (frm_cnt)
`endif
   );

   twiddle_sequencer #(.LOG_N(LOG_N), .ROM_FF(0), .TW_FF(0), .TC_FF(0)) u_dut0 (
      .clock    (clock),
      .reset    (reset),
      .di_en    (di_en),
      .frm_clr  (frm_clr),
      .tw_addr  (tw_addr0),
      .tw_en    (tw_en0),
      .tc_en    (tc_en0),
      .tc_first (tc_first0),
      .tc_last  (tc_last0),
      .busy     (busy0)
`ifdef TWSEQ_FRAME_CNT_EN
      ,
      .frm_cnt  (frm_cnt0)
`endif
   );

   typedef struct {
      int idx;
      bit first;
      bit last;
      int due;
   } sb_t;

   sb_t sb_q[$];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int m_cnt       = 0;
   bit m_run       = 1'b0;
   int m_frm       = 0;
   int m_frm0      = 0;
   int n_tc_en     = 0;
   int n_tc_first  = 0;
   int n_tc_last   = 0;

   task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Twiddle number from the quarter table: Q=0/1/2/3 -> K=0/2/1/3.
   function automatic int ref_addr(input int n);
      int q;
      int p;
      int kk;
      q = n / (N / 4);
      p = n % (N / 4);
      case (q)
         1:       kk = 2;
         2:       kk = 1;
         3:       kk = 3;
         default: kk = 0;
      endcase
      return p * kk;
   endfunction

   task automatic cycle(input bit di, input bit clr);
      int  idx;
      bit  f;
      bit  l;
      bit  exp_busy;
      sb_t e;
      di_en   = di;
      frm_clr = clr;
      @(negedge clock);
      idx = clr ? 0 : m_cnt;
      f   = di && (idx == 0);
      l   = di && (idx == N - 1);

      check_val("tw_addr", tw_addr, ref_addr(idx));
      check_val("tw_en", tw_en, di);
      exp_busy = m_run || (sb_q.size() > 0 && sb_q[0].due < cyc + LAT);
      check_val("busy", busy, exp_busy);
`ifdef TWSEQ_FRAME_CNT_EN
      check_val("frm_cnt", frm_cnt, m_frm);
      check_val("frm_cnt0", frm_cnt0, m_frm0);
`endif
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         e = sb_q.pop_front();
         check_val("tc_en", tc_en, 1);
         check_val("tc_first", tc_first, e.first);
         check_val("tc_last", tc_last, e.last);
         $display("tc idx=%0d first=%0b last=%0b cycle=%0d", e.idx, e.first, e.last, cyc);
         if (e.last) m_frm = (m_frm + 1) % 65536;
      end else begin
         check_val("tc_en_idle", tc_en, 0);
         check_val("tc_first_idle", tc_first, 0);
         check_val("tc_last_idle", tc_last, 0);
      end

      check_val("tw_addr0", tw_addr0, ref_addr(idx));
      check_val("tw_en0", tw_en0, di);
      check_val("tc_en0", tc_en0, di);
      check_val("tc_first0", tc_first0, f);
      check_val("tc_last0", tc_last0, l);
      check_val("busy0", busy0, m_run);
      if (l) m_frm0 = (m_frm0 + 1) % 65536;

      if (tc_en)    n_tc_en++;
      if (tc_first) n_tc_first++;
      if (tc_last)  n_tc_last++;

      if (di) sb_q.push_back('{idx: idx, first: f, last: l, due: cyc + LAT});

      if (clr) begin
         m_cnt = di ? 1 : 0;
         m_run = di;
      end else if (di) begin
         m_run = (m_cnt != N - 1);
         m_cnt = (m_cnt + 1) % N;
      end

      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic reset_cycle();
      reset   = 1'b1;
      di_en   = 1'b0;
      frm_clr = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc++;
      sb_q.delete();
      m_cnt  = 0;
      m_run  = 1'b0;
      m_frm  = 0;
      m_frm0 = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < LAT + 2; i++) cycle(1'b0, 1'b0);
   endtask

   initial begin
      int accepted;
      int guard;
      bit d;

      // reset state, then one gapless frame
      reset_cycle();
      cycle(1'b0, 1'b0);
      for (int i = 0; i < N; i++) cycle(1'b1, 1'b0);
      drain();

      // two frames with random gaps
      n_tc_en    = 0;
      n_tc_first = 0;
      n_tc_last  = 0;
      accepted   = 0;
      guard      = 0;
      while (accepted < 2 * N && guard < 2000) begin
         d = 1'($urandom_range(0, 1));
         cycle(d, 1'b0);
         if (d) accepted++;
         guard++;
      end
      check_val("rand_accepted", accepted, 2 * N);
      drain();
      check_val("rand_tc_en_count", n_tc_en, 2 * N);
      check_val("rand_tc_first_count", n_tc_first, 2);
      check_val("rand_tc_last_count", n_tc_last, 2);

      // realign with a sample at n=20, then a bare realign mid-frame
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b1);
      for (int i = 0; i < N; i++) cycle(1'b1, 1'b0);
      drain();

      // reset mid-frame with samples in flight, then back-to-back frames
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);
      reset_cycle();
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3 * N; i++) cycle(1'b1, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
